branch_predictor: RTL and testbench



---
 rtl/branch_predictor.sv | 92 +++++++++
 tb/tb_branch_predictor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped fetch-side branch predictor with mispredict feedback
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pred_pc             fetch PC looked up combinationally
//   pred_hit/taken/target  prediction for pred_pc (target is pc+4 when not taken)
//   upd_*               resolved branch from execute, learned at the rising edge
//   mispredict          registered one-cycle redirect pulse
//   redirect_pc         correct next PC of the most recent resolved branch
//   mispredict_cnt      saturating mispredict count
module branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      pred_pc,
   output logic             pred_hit,
   output logic             pred_taken,
   output logic [31:0]      pred_target,
   input  logic             upd_en,
   input  logic [31:0]      upd_pc,
   input  logic             upd_taken,
   input  logic [31:0]      upd_target,
   input  logic             upd_pred_taken,
   input  logic [31:0]      upd_pred_target,
   output logic             mispredict,
   output logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] mispredict_cnt
);
   localparam int IDX = $clog2(ENTRIES);
   localparam int TW  = 30 - IDX;
   logic [ENTRIES-1:0] valid;
   logic [TW-1:0]      tags    [ENTRIES];
   logic [31:0]        targets [ENTRIES];
   logic [1:0]         ctr     [ENTRIES];
   logic [IDX-1:0]     p_idx, u_idx;
   logic [TW-1:0]      p_tag, u_tag;
   logic               u_hit, cond;
   logic               unused_bits;

   assign unused_bits = ^{pred_pc[1:0], upd_pc[1:0]};
   assign p_idx = pred_pc[IDX+1:2];
   assign p_tag = pred_pc[31:IDX+2];
   assign u_idx = upd_pc[IDX+1:2];
   assign u_tag = upd_pc[31:IDX+2];

   // Lookup sees only pre-edge table contents; no bypass from a same-cycle update.
   always_comb begin
      pred_hit    = valid[p_idx] && tags[p_idx] == p_tag;
      pred_taken  = pred_hit && ctr[p_idx][1];
      pred_target = pred_taken ? targets[p_idx] : pred_pc + 32'd4;
   end

   assign u_hit = valid[u_idx] && tags[u_idx] == u_tag;
   assign cond  = upd_en && (upd_taken != upd_pred_taken ||
                             (upd_taken && upd_pred_target != upd_target));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
      end else if (upd_en) begin
         if (u_hit)
            ctr[u_idx] <= upd_taken ? (ctr[u_idx] == 2'b11 ? 2'b11 : ctr[u_idx] + 2'd1)
                                    : (ctr[u_idx] == 2'b00 ? 2'b00 : ctr[u_idx] - 2'd1);
         else if (upd_taken) begin
            valid[u_idx] <= 1'b1;
            ctr[u_idx]   <= 2'b10;
         end
      end
   end

   // A taken update either refreshes the target of a hit (tag unchanged) or allocates.
   always_ff @(posedge clk) begin
      if (upd_en && upd_taken) begin
         tags[u_idx]    <= u_tag;
         targets[u_idx] <= upd_target;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mispredict     <= 1'b0;
         redirect_pc    <= '0;
         mispredict_cnt <= '0;
      end else begin
         mispredict <= cond;
         if (upd_en) redirect_pc <= upd_taken ? upd_target : upd_pc + 32'd4;
         if (cond && !(&mispredict_cnt)) mispredict_cnt <= mispredict_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors, corner sequences and a randomized model check
module tb_branch_predictor;
   logic        clk = 0, rst_n = 1;
   logic [31:0] pred_pc = 0, upd_pc = 0, upd_target = 0, upd_pred_target = 0;
   logic        upd_en = 0, upd_taken = 0, upd_pred_taken = 0;
   logic        pred_hit, pred_taken, mispredict;
   logic [31:0] pred_target, redirect_pc;
   logic [3:0]  mispredict_cnt;

   branch_predictor #(.ENTRIES(16), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_hit(pred_hit),
      .pred_taken(pred_taken), .pred_target(pred_target), .upd_en(upd_en),
      .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
      .mispredict(mispredict), .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt));

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic [31:0] pc, input logic t,
                        input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
      upd_en = en; upd_pc = pc; upd_taken = t; upd_target = tg;
      upd_pred_taken = pt; upd_pred_target = ptg;
   endtask

   // Reference model: per slot remembers the full PC of the branch that owns it and
   // a confidence level 0..3; two branches share a slot when (pc/4)%16 agrees and
   // they are the same branch when pc/64 agrees.
   bit          mv [16];
   logic [31:0] mpc[16], mtg[16];
   int          mst[16];
   logic        emp;
   logic [31:0] erpc;
   int          ecnt;

   function automatic int slot(input logic [31:0] pc);
      return int'((pc / 4) % 16);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return mv[slot(pc)] && (mpc[slot(pc)] / 64) == (pc / 64);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 16; i++) begin mv[i] = 0; mst[i] = 1; end
      emp = 0; erpc = 0; ecnt = 0;
   endtask

   task automatic m_update();
      int  s;
      bit  c;
      s = slot(upd_pc);
      c = upd_en && ((upd_taken != upd_pred_taken) || (upd_taken && upd_pred_target != upd_target));
      emp = c;
      if (upd_en) erpc = upd_taken ? upd_target : upd_pc + 4;
      if (c && ecnt < 15) ecnt++;
      if (upd_en) begin
         if (m_hit(upd_pc)) begin
            mst[s] = upd_taken ? (mst[s] < 3 ? mst[s] + 1 : 3) : (mst[s] > 0 ? mst[s] - 1 : 0);
            if (upd_taken) mtg[s] = upd_target;
         end else if (upd_taken) begin
            mv[s] = 1; mpc[s] = upd_pc; mtg[s] = upd_target; mst[s] = 2;
         end
      end
   endtask

   typedef struct {
      logic en; logic [31:0] pc; logic t; logic [31:0] tg; logic pt; logic [31:0] ptg;
      logic [31:0] lpc; logic hit; logic tk; logic [31:0] ltg;
      logic mp; logic [31:0] rpc; logic [3:0] cnt;
   } vec_t;
   vec_t v[11];

   initial begin
      v[0]  = '{1, 32'h100, 1, 32'h80,  0, 32'h104, 32'h100, 1, 1, 32'h80,  1, 32'h80,  1};
      v[1]  = '{1, 32'h100, 1, 32'h80,  1, 32'h80,  32'h100, 1, 1, 32'h80,  0, 32'h80,  1};
      v[2]  = '{1, 32'h100, 1, 32'h80,  1, 32'h80,  32'h100, 1, 1, 32'h80,  0, 32'h80,  1};
      v[3]  = '{1, 32'h100, 1, 32'h80,  1, 32'h80,  32'h100, 1, 1, 32'h80,  0, 32'h80,  1};
      v[4]  = '{1, 32'h100, 0, 32'h0,   1, 32'h80,  32'h100, 1, 1, 32'h80,  1, 32'h104, 2};
      v[5]  = '{1, 32'h100, 0, 32'h0,   1, 32'h80,  32'h100, 1, 0, 32'h104, 1, 32'h104, 3};
      v[6]  = '{1, 32'h100, 1, 32'h80,  0, 32'h104, 32'h100, 1, 1, 32'h80,  1, 32'h80,  4};
      v[7]  = '{1, 32'h100, 1, 32'h90,  1, 32'h80,  32'h100, 1, 1, 32'h90,  1, 32'h90,  5};
      v[8]  = '{1, 32'h140, 1, 32'h200, 0, 32'h144, 32'h140, 1, 1, 32'h200, 1, 32'h200, 6};
      v[9]  = '{0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h100, 0, 0, 32'h104, 0, 32'h200, 6};
      v[10] = '{1, 32'h180, 0, 32'h0,   0, 32'h184, 32'h140, 1, 1, 32'h200, 0, 32'h184, 6};

      #1 rst_n = 0;
      pred_pc = 32'h100;
      #2;
      chk("reset_hit", 32'(pred_hit), 0);
      chk("reset_taken", 32'(pred_taken), 0);
      chk("reset_target", pred_target, 32'h104);
      chk("reset_mp", 32'(mispredict), 0);
      chk("reset_cnt", 32'(mispredict_cnt), 0);
      chk("reset_rpc", redirect_pc, 0);
      @(negedge clk) rst_n = 1;

      for (int i = 0; i < 11; i++) begin
         drive(v[i].en, v[i].pc, v[i].t, v[i].tg, v[i].pt, v[i].ptg);
         tick();
         upd_en = 0;
         pred_pc = v[i].lpc;
         #1;
         chk($sformatf("v%0d_hit", i), 32'(pred_hit), 32'(v[i].hit));
         chk($sformatf("v%0d_taken", i), 32'(pred_taken), 32'(v[i].tk));
         chk($sformatf("v%0d_target", i), pred_target, v[i].ltg);
         chk($sformatf("v%0d_mp", i), 32'(mispredict), 32'(v[i].mp));
         chk($sformatf("v%0d_rpc", i), redirect_pc, v[i].rpc);
         chk($sformatf("v%0d_cnt", i), 32'(mispredict_cnt), 32'(v[i].cnt));
      end

      // Same-cycle lookup and update at an aliased slot: old view first, new after edge.
      pred_pc = 32'h100;
      drive(1, 32'h100, 1, 32'h300, 0, 32'h104);
      #1;
      chk("same_cycle_old_hit", 32'(pred_hit), 0);
      chk("same_cycle_old_target", pred_target, 32'h104);
      tick();
      upd_en = 0;
      #1;
      chk("same_cycle_new_hit", 32'(pred_hit), 1);
      chk("same_cycle_new_target", pred_target, 32'h300);
      chk("same_cycle_mp", 32'(mispredict), 1);
      chk("same_cycle_cnt", 32'(mispredict_cnt), 7);

      // Back-to-back pulses, then the pulse drops.
      drive(1, 32'h100, 0, 32'h0, 1, 32'h300);
      tick();
      chk("b2b_mp1", 32'(mispredict), 1);
      tick();
      chk("b2b_mp2", 32'(mispredict), 1);
      chk("b2b_cnt", 32'(mispredict_cnt), 9);
      upd_en = 0;
      tick();
      chk("b2b_drop", 32'(mispredict), 0);
      chk("b2b_rpc_hold", redirect_pc, 32'h104);

      // Reset while a pulse is pending.
      drive(1, 32'h100, 1, 32'h500, 0, 32'h104);
      tick();
      upd_en = 0;
      chk("pre_reset_mp", 32'(mispredict), 1);
      rst_n = 0;
      #1;
      chk("midreset_mp", 32'(mispredict), 0);
      chk("midreset_cnt", 32'(mispredict_cnt), 0);
      chk("midreset_rpc", redirect_pc, 0);
      chk("midreset_hit", 32'(pred_hit), 0);
      @(negedge clk) rst_n = 1;

      // Counter saturation.
      drive(1, 32'h40, 0, 32'h0, 1, 32'h80);
      for (int i = 0; i < 17; i++) begin
         tick();
         if (i == 14) chk("cnt_reaches_max", 32'(mispredict_cnt), 15);
      end
      chk("cnt_saturated", 32'(mispredict_cnt), 15);
      upd_en = 0;

      // Randomized traffic against the model.
      rst_n = 0;
      m_reset();
      @(negedge clk) rst_n = 1;
      for (int n = 0; n < 400; n++) begin
         logic [31:0] tg;
         logic        eh, et;
         logic [31:0] etg;
         tg = 32'($urandom_range(0, 255)) << 2;
         drive($urandom_range(0, 3) != 0, 32'($urandom_range(0, 63)) << 2, 1'($urandom),
               tg, 1'($urandom), ($urandom_range(0, 1) != 0) ? tg : 32'($urandom_range(0, 255)) << 2);
         pred_pc = 32'($urandom_range(0, 63)) << 2;
         #1;
         eh  = m_hit(pred_pc);
         et  = eh && mst[slot(pred_pc)] >= 2;
         etg = et ? mtg[slot(pred_pc)] : pred_pc + 4;
         chk("rnd_hit", 32'(pred_hit), 32'(eh));
         chk("rnd_taken", 32'(pred_taken), 32'(et));
         chk("rnd_target", pred_target, etg);
         m_update();
         tick();
         chk("rnd_mp", 32'(mispredict), 32'(emp));
         chk("rnd_rpc", redirect_pc, erpc);
         chk("rnd_cnt", 32'(mispredict_cnt), 32'(ecnt));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
